ec_line_sched: RTL and testbench
================================

Name: ec_line_sched

Overview:
- Scheduler for the encoding engine's per-line compute sequence.
- Per data line: pops one line from the input-buffer FIFO, loads it into the engine, then issues M compute cycles.
- Each compute cycle produces one parity packet, written to the output-buffer FIFO.
- Runs a configured number of lines per job, stalls on input-empty or output-full, and reports job done and stall statistics to the control registers.

Parameters:
- M_MAX, 4, width of the M configuration field (M from 1 to 2^M_MAX-1)
- LCNT_W, 16, width of the job line-count field
- STALL_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job start pulse, sampled in IDLE only
- abort  in  1  synchronous job abort, any state
- m_cfg  in  M_MAX  compute cycles per line (M)
- line_cnt_cfg  in  LCNT_W  lines in the job
- inbuf_fifo_empty  in  1  input FIFO empty
- inbuf_fifo_rd_rq  out  1  pop request; data returns exactly 1 cycle later
- inbuf_fifo_rd_val  in  1  popped line valid, 1 cycle after rd_rq
- eng_load  out  1  engine captures the FIFO output line this cycle
- eng_cyc_en  out  1  engine performs compute cycle eng_cyc_idx
- eng_cyc_idx  out  M_MAX  index of the current compute cycle, 0..M-1
- eng_last_cyc  out  1  eng_cyc_en and eng_cyc_idx==M-1
- outbuf_fifo_full  in  1  output FIFO full
- outbuf_fifo_wr_rq  out  1  push the engine parity packet
- busy  out  1  job in progress (state not IDLE)
- done  out  1  one-cycle pulse when the job completes normally
- cfg_err  out  1  one-cycle pulse when start is rejected
- stall_cnt  out  STALL_W  stall cycles in the current/last job, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal counters 0.
- Abort handling:
  - abort (highest priority) in any state: next state IDLE, counters cleared except stall_cnt.
  - If abort arrives in LOAD, the returning line is dropped and eng_load is held 0.
- States: IDLE, FETCH, LOAD, COMPUTE, DONE.
- IDLE:
  - On start with m_cfg==0 or line_cnt_cfg==0: pulse cfg_err next cycle, stay IDLE.
  - Otherwise: latch m_cfg and line_cnt_cfg into m_q and lcnt_q, clear lines_done, clear stall_cnt, go to FETCH.
  - Configuration changes mid-job are ignored.
- FETCH:
  - If ~inbuf_fifo_empty: rd_rq=1 this cycle, go to LOAD.
  - Else: stall_cnt+1, stay in FETCH.
- LOAD:
  - eng_load = inbuf_fifo_rd_val.
  - On rd_val: go to COMPUTE, cyc_idx=0.
  - If rd_val is absent: stay in LOAD (protocol hold). No rd_rq is issued.
- COMPUTE:
  - eng_cyc_en = outbuf_fifo_wr_rq = ~outbuf_fifo_full.
  - When full: stall_cnt+1 and cyc_idx holds.
  - On eng_cyc_en with cyc_idx<m_q-1: cyc_idx+1.
- Last compute cycle (eng_cyc_en and cyc_idx==m_q-1): eng_last_cyc=1, lines_done+1, cyc_idx wraps to 0, then:
  - if lines_done+1==lcnt_q: go to DONE;
  - else if ~inbuf_fifo_empty: rd_rq=1 in the same cycle, go to LOAD;
  - else: go to FETCH.
- DONE: done=1 for one cycle, go to IDLE; busy drops in the cycle after DONE.
- Throughput: exactly one bubble (LOAD) per line when not stalled.
  - Unstalled job time: from the cycle start is seen to the done pulse, 2 + N*(M+1) cycles.
- Read/write limits: at most one rd_rq outstanding. Never rd_rq while the FIFO is empty; never wr_rq while the output FIFO is full.
- stall_cnt: saturates at all-ones (no wrap). It is held after DONE or abort until the next accepted start.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: abort wins, no job starts.
- Arithmetic: cyc_idx and its compare use M_MAX-bit unsigned arithmetic. lines_done uses LCNT_W bits; lcnt_q==2^LCNT_W-1 must complete without overflow.

Test Plan:
- Basic job: M=3, lines=2, input FIFO preloaded, output never full.
  - Expect 2 rd_rq, 2 eng_load, 6 wr_rq with idx sequence 0,1,2,0,1,2.
  - done asserts 10 cycles after the start cycle; stall_cnt=0.
- Output backpressure: M=4, lines=1, outbuf_fifo_full held for 3 cycles at idx=2.
  - Expect cyc_idx held at 2, exactly 4 wr_rq, stall_cnt=3, done asserted.
- Input underrun: M=2, lines=3, FIFO holds 1 line and the 2nd line arrives 5 cycles after the 1st line finishes.
  - Expect FETCH dwell of 5 cycles, stall_cnt=5, and no rd_rq while the FIFO is empty.
- Config error: start with m_cfg=0, then with line_cnt_cfg=0.
  - Expect a cfg_err pulse each time, busy stays 0, no FIFO activity.
- Abort in LOAD: M=5, lines=4, abort in the cycle rd_rq was issued for line 2.
  - Expect eng_load=0 on the following rd_val, IDLE next cycle, no done.
  - A new job then runs normally.
- Async reset mid-COMPUTE: assert rst at idx=1.
  - Expect all outputs 0 immediately, state IDLE, busy=0 after release.

Source files
------------

// File: rtl/ec_line_sched_if.sv
// Datapath handshake bundle between the line scheduler, the in/out buffer FIFOs and the engine.
// master = scheduler side, slave = FIFO/engine side.
interface ec_line_sched_if #(
   parameter int unsigned M_MAX = 4
);
   logic             inbuf_fifo_empty;
   logic             inbuf_fifo_rd_rq;
   logic             inbuf_fifo_rd_val;
   logic             eng_load;
   logic             eng_cyc_en;
   logic [M_MAX-1:0] eng_cyc_idx;
   logic             eng_last_cyc;
   logic             outbuf_fifo_full;
   logic             outbuf_fifo_wr_rq;

   modport master (
      input  inbuf_fifo_empty, inbuf_fifo_rd_val, outbuf_fifo_full,
      output inbuf_fifo_rd_rq, eng_load, eng_cyc_en, eng_cyc_idx, eng_last_cyc,
             outbuf_fifo_wr_rq
   );

   modport slave (
      output inbuf_fifo_empty, inbuf_fifo_rd_val, outbuf_fifo_full,
      input  inbuf_fifo_rd_rq, eng_load, eng_cyc_en, eng_cyc_idx, eng_last_cyc,
             outbuf_fifo_wr_rq
   );
endinterface

// File: rtl/ec_line_sched.sv
// Per-line compute scheduler: pop a line, load it into the engine, run M compute cycles
// (one parity packet each), repeat for the job's line count; tracks stall cycles.
module ec_line_sched #(
   parameter int unsigned M_MAX   = 4,
   parameter int unsigned LCNT_W  = 16,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [M_MAX-1:0]   m_cfg,
   input  logic [LCNT_W-1:0]  line_cnt_cfg,
   ec_line_sched_if.master    bus,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [STALL_W-1:0] stall_cnt
);
   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StCompute, StDone} state_e;

   state_e             state_q, state_d;
   logic [M_MAX-1:0]   m_q, m_d, cyc_q, cyc_d;
   logic [LCNT_W-1:0]  lcnt_q, lcnt_d, lines_q, lines_d, lines_inc;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               cfg_err_q, cfg_err_d;
   logic               stall_inc, stall_clr;
   logic               rd_rq, load, cyc_en, last_cyc, wr_rq;

   assign lines_inc = lines_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      lcnt_d    = lcnt_q;
      cyc_d     = cyc_q;
      lines_d   = lines_q;
      cfg_err_d = 1'b0;
      stall_inc = 1'b0;
      stall_clr = 1'b0;
      rd_rq     = 1'b0;
      load      = 1'b0;
      cyc_en    = 1'b0;
      last_cyc  = 1'b0;
      wr_rq     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (m_cfg == '0 || line_cnt_cfg == '0) begin
                  cfg_err_d = 1'b1;
               end else begin
                  m_d       = m_cfg;
                  lcnt_d    = line_cnt_cfg;
                  lines_d   = '0;
                  stall_clr = 1'b1;
                  state_d   = StFetch;
               end
            end
         end
         StFetch: begin
            if (!bus.inbuf_fifo_empty) begin
               rd_rq   = 1'b1;
               state_d = StLoad;
            end else begin
               stall_inc = 1'b1;
            end
         end
         StLoad: begin
            // A line returning into an aborted job is dropped.
            load = bus.inbuf_fifo_rd_val & ~abort;
            if (bus.inbuf_fifo_rd_val) begin
               cyc_d   = '0;
               state_d = StCompute;
            end
         end
         StCompute: begin
            if (bus.outbuf_fifo_full) begin
               stall_inc = 1'b1;
            end else begin
               cyc_en = 1'b1;
               wr_rq  = 1'b1;
               if (cyc_q == m_q - 1'b1) begin
                  last_cyc = 1'b1;
                  cyc_d    = '0;
                  lines_d  = lines_inc;
                  if (lines_inc == lcnt_q) begin
                     state_d = StDone;
                  end else if (!bus.inbuf_fifo_empty) begin
                     // Back-to-back prefetch keeps the per-line bubble to the LOAD cycle.
                     rd_rq   = 1'b1;
                     state_d = StLoad;
                  end else begin
                     state_d = StFetch;
                  end
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d   = StIdle;
         cyc_d     = '0;
         lines_d   = '0;
         cfg_err_d = 1'b0;
         stall_inc = 1'b0;
         stall_clr = 1'b0;
      end

      stall_d = stall_q;
      if (stall_clr) begin
         stall_d = '0;
      end else if (stall_inc && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         m_q       <= '0;
         lcnt_q    <= '0;
         cyc_q     <= '0;
         lines_q   <= '0;
         stall_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         lcnt_q    <= lcnt_d;
         cyc_q     <= cyc_d;
         lines_q   <= lines_d;
         stall_q   <= stall_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign bus.inbuf_fifo_rd_rq  = rd_rq;
   assign bus.eng_load          = load;
   assign bus.eng_cyc_en        = cyc_en;
   assign bus.eng_cyc_idx       = cyc_q;
   assign bus.eng_last_cyc      = last_cyc;
   assign bus.outbuf_fifo_wr_rq = wr_rq;
   assign busy                  = (state_q != StIdle);
   assign done                  = (state_q == StDone);
   assign cfg_err               = cfg_err_q;
   assign stall_cnt             = stall_q;
endmodule

// File: tb/tb_ec_line_sched.sv
// Directed bench for ec_line_sched: expected parity-packet writes are queued per job and
// popped by a monitor on every wr_rq; timing and statistics are checked by the stimulus.
module tb_ec_line_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [3:0]  m_cfg;
   logic [15:0] line_cnt_cfg;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [15:0] stall_cnt;

   ec_line_sched_if #(.M_MAX(4)) bus ();

   ec_line_sched #(.M_MAX(4), .LCNT_W(16), .STALL_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .m_cfg        (m_cfg),
      .line_cnt_cfg (line_cnt_cfg),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   int   cyc_n = 0;
   int   in_pushed = 0;
   int   in_popped = 0;
   logic rd_val_q;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Input FIFO model: line count only, data returns one cycle after the pop request.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_val_q <= 1'b0;
      end else begin
         rd_val_q <= bus.inbuf_fifo_rd_rq;
         if (bus.inbuf_fifo_rd_rq) in_popped <= in_popped + 1;
      end
   end

   assign bus.inbuf_fifo_empty  = (in_pushed == in_popped);
   assign bus.inbuf_fifo_rd_val = rd_val_q;

   int         checks = 0;
   int         errors = 0;
   int         n_rd = 0, n_load = 0, n_wr = 0, n_done = 0;
   logic [4:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int outs();
      return 32'({bus.inbuf_fifo_rd_rq, bus.eng_load, bus.eng_cyc_en, bus.eng_cyc_idx,
                  bus.eng_last_cyc, bus.outbuf_fifo_wr_rq, busy, done, cfg_err, stall_cnt});
   endfunction

   // Queue the {last, idx} packets one line of M compute cycles must produce.
   task automatic exp_line(input int m);
      for (int i = 0; i < m; i++) exp_q.push_back({i == m - 1, 4'(i)});
   endtask

   task automatic start_job(input int m, input int n, output int t0);
      @(posedge clk); #1;
      m_cfg        = 4'(m);
      line_cnt_cfg = 16'(n);
      start        = 1'b1;
      t0           = cyc_n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idx(input int idx);
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.eng_cyc_en && bus.eng_cyc_idx == 4'(idx)) seen = 1;
      end
      if (!seen) check("wait_idx_timeout", 0, 1);
   endtask

   task automatic wait_done(input string name, input int t0, input int exp_len);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         check({name, "_done_timeout"}, 0, 1);
      end else begin
         check({name, "_done_latency"}, cyc_n - t0, exp_len);
         check({name, "_busy_at_done"}, 32'(busy), 1);
         @(negedge clk);
         check({name, "_busy_after_done"}, 32'(busy), 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0, b_rd, b_load, b_wr, b_done;
      rst = 1'b1; start = 1'b0; abort = 1'b0; m_cfg = '0; line_cnt_cfg = '0;
      bus.outbuf_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 0);
      rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (bus.inbuf_fifo_rd_rq) begin
                  n_rd++;
                  check("rd_rq_while_empty", 32'(bus.inbuf_fifo_empty), 0);
               end
               if (bus.eng_load) n_load++;
               if (bus.outbuf_fifo_wr_rq) begin
                  n_wr++;
                  check("wr_rq_while_full", 32'(bus.outbuf_fifo_full), 0);
                  if (exp_q.size() == 0) check("unexpected_wr", 32'(bus.eng_cyc_idx), 255);
                  else check("wr_pkt", 32'({bus.eng_last_cyc, bus.eng_cyc_idx}),
                             32'(exp_q.pop_front()));
               end
               if (done) n_done++;
            end
         end
      join_none

      // Basic job: M=3, 2 lines, FIFO preloaded.
      in_pushed += 2;
      exp_line(3); exp_line(3);
      b_rd = n_rd; b_load = n_load; b_wr = n_wr;
      start_job(3, 2, t0);
      wait_done("basic", t0, 10);
      check("basic_rd_count", n_rd - b_rd, 2);
      check("basic_load_count", n_load - b_load, 2);
      check("basic_wr_count", n_wr - b_wr, 6);
      check("basic_stall", 32'(stall_cnt), 0);
      check("basic_q_empty", exp_q.size(), 0);

      // Output backpressure: M=4, 1 line, full for 3 cycles at idx 2.
      in_pushed += 1;
      exp_line(4);
      b_wr = n_wr;
      start_job(4, 1, t0);
      wait_idx(1);
      @(posedge clk); #1;
      bus.outbuf_fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_idx_held", 32'(bus.eng_cyc_idx), 2);
         check("bp_no_wr", 32'(bus.outbuf_fifo_wr_rq), 0);
      end
      @(posedge clk); #1;
      bus.outbuf_fifo_full = 1'b0;
      wait_done("bp", t0, 10);
      check("bp_wr_count", n_wr - b_wr, 4);
      check("bp_stall", 32'(stall_cnt), 3);

      // Input underrun: M=2, 3 lines, only one line present at start.
      in_pushed += 1;
      exp_line(2); exp_line(2); exp_line(2);
      start_job(2, 3, t0);
      wait_idx(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ur_no_rd_when_empty", 32'(bus.inbuf_fifo_rd_rq), 0);
      end
      @(posedge clk); #1;
      in_pushed += 2;
      wait_done("ur", t0, 17);
      check("ur_stall", 32'(stall_cnt), 5);

      // Config errors; a line sits in the FIFO but must not be popped.
      in_pushed += 1;
      b_rd = n_rd; b_wr = n_wr;
      start_job(0, 5, t0);
      @(negedge clk);
      check("cfg_m0_err", 32'(cfg_err), 1);
      check("cfg_m0_busy", 32'(busy), 0);
      @(negedge clk);
      check("cfg_m0_err_pulse", 32'(cfg_err), 0);
      start_job(3, 0, t0);
      @(negedge clk);
      check("cfg_l0_err", 32'(cfg_err), 1);
      check("cfg_l0_busy", 32'(busy), 0);
      @(negedge clk);
      check("cfg_l0_err_pulse", 32'(cfg_err), 0);
      check("cfg_no_rd", n_rd - b_rd, 0);
      check("cfg_no_wr", n_wr - b_wr, 0);

      // Abort in the cycle line 2 is requested: M=5, 4 lines.
      in_pushed += 1;
      exp_line(5);
      b_done = n_done; b_load = n_load;
      start_job(5, 4, t0);
      wait_idx(3);
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      check("ab_last_cyc", 32'(bus.eng_last_cyc), 1);
      check("ab_rd_rq", 32'(bus.inbuf_fifo_rd_rq), 1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("ab_rd_val_back", 32'(rd_val_q), 1);
      check("ab_load_dropped", 32'(bus.eng_load), 0);
      check("ab_idle", 32'(busy), 0);
      repeat (15) @(negedge clk);
      check("ab_no_done", n_done - b_done, 0);
      check("ab_load_count", n_load - b_load, 1);
      check("ab_q_empty", exp_q.size(), 0);

      // Normal job after abort: M=1, 2 lines.
      in_pushed += 2;
      exp_line(1); exp_line(1);
      start_job(1, 2, t0);
      wait_done("post_ab", t0, 6);
      check("post_ab_stall", 32'(stall_cnt), 0);
      check("post_ab_q_empty", exp_q.size(), 0);

      // Asynchronous reset in the middle of COMPUTE at idx 1.
      in_pushed += 1;
      exp_q.push_back({1'b0, 4'd0});
      b_done = n_done;
      start_job(3, 1, t0);
      wait_idx(0);
      @(posedge clk); #1;
      check("rst_pre_idx", 32'(bus.eng_cyc_idx), 1);
      #2 rst = 1'b1;
      #1 check("rst_async_outputs", outs(), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy_after", 32'(busy), 0);
      check("rst_outputs_after", outs(), 0);
      check("rst_no_done", n_done - b_done, 0);
      check("rst_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
